// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } scan_state_t;

    typedef logic [3:0] key_code_t;
    typedef logic [1:0] idx_t;

    function automatic key_code_t make_code(input idx_t row, input idx_t col);
        return {row, col};
    endfunction

    // Lowest-numbered active-low bit wins when several rows are down.
    function automatic idx_t first_low(input logic [3:0] v);
        idx_t idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else if (!v[3]) idx = 2'd3;
        else            idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event channel: valid/ready key code plus held and overrun status.
interface keypad_scanner_if;
    import keypad_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_ready;
    logic      key_held;
    logic      overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous row lines.
// Latency 2 clocks; no backpressure (free-running sampler).
module keypad_sync2 #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobe, row debounce, one key code per press (auto-repeat with KEYPAD_REPEAT_EN).
// Latency 2 + up to 4*SCAN_DIV + DEBOUNCE_CYC + 1 clocks from a clean press to key_valid.
// Single-entry output register; an event arriving while it is full and not draining is dropped with an overrun pulse.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CYC  = 20000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               row_n_i,
    output logic [3:0]               col_n_o,
    keypad_scanner_if.master         key_if
);
    // One timer serves scan, debounce and repeat phases; they never run at the same time.
    localparam int MAX_SD  = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int MAX_RP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_MAX = (MAX_SD > MAX_RP) ? MAX_SD : MAX_RP;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [TW-1:0] RPT_FIRST_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RPT_NEXT_LAST  = TW'(REPEAT_PERIOD - 1);
`endif

    logic [3:0] rs;

    keypad_sync2 #(.W(4), .RST_VAL(4'hF)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n_i),
        .q_o   (rs)
    );

    scan_state_t    state_q, state_d;
    idx_t           col_q, col_d;
    idx_t           row_q, row_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           held_q, held_d;
    key_code_t      code_q, code_d;
    logic           vld_q, vld_d;
    logic           ovr_q, ovr_d;
`ifdef KEYPAD_REPEAT_EN
    logic           rpt_first_q, rpt_first_d;
`endif

    logic ev;
    logic row_low;
    logic xfer;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            tmr_q   <= '0;
            held_q  <= 1'b0;
            code_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tmr_q   <= tmr_d;
            held_q  <= held_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    // Next-state logic; every timer path resets or stops at its terminal count, so it never wraps.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        tmr_d   = tmr_q;
        held_d  = held_q;
        ev      = 1'b0;
        row_low = ~rs[row_q];
`ifdef KEYPAD_REPEAT_EN
        rpt_first_d = rpt_first_q;
`endif
        unique case (state_q)
            SCAN: begin
                if (tmr_q == SCAN_LAST) begin
                    tmr_d = '0;
                    if (rs != 4'hF) begin
                        row_d   = first_low(rs);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    tmr_d   = '0;
                end else if (tmr_q == DB_LAST) begin
                    ev      = 1'b1;
                    held_d  = 1'b1;
                    state_d = PRESSED;
                    tmr_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!row_low) begin
                    state_d = RELEASE_DB;
                    tmr_d   = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (tmr_q == (rpt_first_q ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
                    ev          = 1'b1;
                    tmr_d       = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            RELEASE_DB: begin
                // Row dropping again is release bounce: back to PRESSED without a new event.
                if (row_low) begin
                    state_d = PRESSED;
                    tmr_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                    rpt_first_d = 1'b1;
`endif
                end else if (tmr_q == DB_LAST) begin
                    state_d = SCAN;
                    held_d  = 1'b0;
                    col_d   = col_q + 2'd1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs: column strobe and the single-entry event register.
    always_comb begin
        col_n_o = ~(4'b0001 << col_q);
        xfer    = vld_q & key_if.key_ready;
        code_d  = code_q;
        vld_d   = vld_q;
        ovr_d   = 1'b0;
        if (ev) begin
            if (!vld_q || xfer) begin
                code_d = make_code(row_q, col_q);
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            vld_d = 1'b0;
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = vld_q;
    assign key_if.key_held  = held_q;
    assign key_if.overrun   = ovr_q;
endmodule
